// File: rtl/fse_cfg_pkg.sv
// Shared definitions for the configuration frame loader: FSM encoding,
// error codes reported on o_err_code, and the default frame start marker.
// No ports; imported by cfg_frame_loader and its sub-modules.
package fse_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DHI  = 3'd2,
        ST_DLO  = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/cfg_frame_loader_byte_timeout.sv
// Purpose: idle-cycle counter used to abandon a stalled frame.
// Latency: expired is a decode of the registered count, valid the cycle the count hits TIMEOUT-1.
// Backpressure: none; counts whenever enable is high, clear has priority.
// Ports: i_clock, i_reset (sync, active-high), clear, enable -> expired.
module byte_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cfg_frame_loader.sv
// Purpose: parse SYNC,ADDR,DHI,DLO,CSUM byte frames into config register writes.
// Latency: o_wr_en / o_err one cycle after the CSUM strobe (or after the timeout expiry cycle).
// Backpressure: none; every i_valid byte is consumed, back-to-back strobes supported.
// Ports: i_clock, i_reset (sync, active-high), i_valid/i_data in;
//        o_wr_en/o_wr_addr/o_wr_data, o_err/o_err_code, o_busy out (all registered).
module cfg_frame_loader
    import fse_cfg_pkg::*;
#(
    parameter int           W       = 8,
    parameter logic [W-1:0] SYNC    = W'(SYNC_DEFAULT),
    parameter int           TIMEOUT = 1024
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_valid,
    input  logic [W-1:0]   i_data,
    output logic           o_wr_en,
    output logic [W-1:0]   o_wr_addr,
    output logic [2*W-1:0] o_wr_data,
    output logic           o_err,
    output logic [1:0]     o_err_code,
    output logic           o_busy
);

    state_t           state_q,    state_d;
    logic [W-1:0]     addr_q,     addr_d;
    logic [W-1:0]     dhi_q,      dhi_d;
    logic [W-1:0]     dlo_q,      dlo_d;
    logic             wr_en_q,    wr_en_d;
    logic [W-1:0]     wr_addr_q,  wr_addr_d;
    logic [2*W-1:0]   wr_data_q,  wr_data_d;
    logic             err_q,      err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             busy_q,     busy_d;

    logic tmo_expired;
    logic tmo_enable;
    logic tmo_clear;
    logic tmo_fire;

    // Count only idle cycles inside a frame; a byte arriving in the expiry
    // cycle suppresses the fire because enable drops with i_valid.
    assign tmo_enable = (state_q != ST_IDLE) && !i_valid;
    assign tmo_fire   = tmo_expired && tmo_enable;
    assign tmo_clear  = i_valid || (state_q == ST_IDLE) || tmo_fire;

    byte_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_byte_timeout (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dhi_d      = dhi_q;
        dlo_d      = dlo_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_d      = 1'b0;
        err_code_d = ERR_NONE;

        if (i_valid) begin
            case (state_q)
                ST_IDLE: begin
                    // Non-SYNC bytes between frames are line noise, dropped silently.
                    if (i_data == SYNC) begin
                        state_d = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    addr_d  = i_data;
                    state_d = ST_DHI;
                end
                ST_DHI: begin
                    dhi_d   = i_data;
                    state_d = ST_DLO;
                end
                ST_DLO: begin
                    dlo_d   = i_data;
                    state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    if (i_data == (addr_q ^ dhi_q ^ dlo_q)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = {dhi_q, dlo_q};
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (tmo_fire) begin
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            dhi_q      <= '0;
            dlo_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dhi_q      <= dhi_d;
            dlo_q      <= dlo_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
        end
    end

    assign o_wr_en    = wr_en_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_err      = err_q;
    assign o_err_code = err_code_q;
    assign o_busy     = busy_q;

endmodule

// File: doc/cfg_frame_loader.md
CFG_FRAME_LOADER -- requirements
Module: cfg_frame_loader

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning byte width of i_data.
REQ-002 The block SHALL have parameter SYNC, default 8'hA5, meaning frame start marker.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum idle cycles allowed between bytes inside a frame (minimum 2).
REQ-004 The block SHALL have port i_clock, input, 1, the clock.
REQ-005 The block SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port i_valid, input, 1, a one-cycle byte strobe driven by the deserialiser ready pulse.
REQ-007 The block SHALL have port i_data, input, W, the byte qualified by i_valid.
REQ-008 The block SHALL have port o_wr_en, output, 1, a one-cycle configuration write strobe.
REQ-009 The block SHALL have port o_wr_addr, output, W, the register address.
REQ-010 The block SHALL have port o_wr_data, output, 2*W, the register data.
REQ-011 The block SHALL have port o_err, output, 1, a one-cycle error strobe.
REQ-012 The block SHALL have port o_err_code, output, 2, with 00 = none, 01 = checksum, 10 = timeout.
REQ-013 The block SHALL have port o_busy, output, 1, high while a frame is in progress (state not IDLE).

Function
REQ-014 The frame format SHALL be SYNC, ADDR, DHI, DLO, CSUM, where CSUM = ADDR ^ DHI ^ DLO.
REQ-015 The FSM SHALL have states IDLE, ADDR, DHI, DLO and CSUM; each accepted byte (i_valid=1) SHALL advance exactly one state.
REQ-016 In IDLE, a byte equal to SYNC SHALL move the FSM to ADDR; any other byte SHALL be discarded silently with no o_err.
REQ-017 In ADDR, DHI and DLO, the FSM SHALL latch the byte into internal shadow registers, and SHALL NOT treat a SYNC value in these positions as a resync.
REQ-018 In CSUM with a matching checksum, the block SHALL, in the cycle after the CSUM strobe, assert o_wr_en for exactly 1 cycle and update o_wr_addr and o_wr_data = {DHI,DLO}.
REQ-019 In CSUM with a mismatching checksum, the block SHALL, in the cycle after the CSUM strobe, assert o_err=1 with o_err_code=01 for 1 cycle, and SHALL leave o_wr_addr and o_wr_data unchanged.
REQ-020 After CSUM, the FSM SHALL return to IDLE regardless of checksum result.
REQ-021 o_wr_addr and o_wr_data SHALL hold their last written values between writes.
REQ-022 o_err_code SHALL be 00 whenever o_err=0.
REQ-023 A timeout counter SHALL clear on every accepted byte and on entry to IDLE, and SHALL increment every cycle while not in IDLE and i_valid=0.
REQ-024 When the timeout counter reaches TIMEOUT-1 with i_valid=0, the block SHALL return the FSM to IDLE and, on the next cycle, assert o_err=1 with o_err_code=10 for 1 cycle.
REQ-025 If i_valid=1 in the same cycle that the counter reaches TIMEOUT-1, the byte SHALL win: it is accepted, the counter clears and no timeout error is raised.
REQ-026 Back-to-back i_valid on consecutive cycles SHALL be accepted without loss, including a SYNC arriving in the cycle immediately after CSUM.
REQ-027 o_wr_en and o_err SHALL never be asserted in the same cycle.

Reset
REQ-028 On i_reset=1 at a clock edge, the block SHALL force the FSM to IDLE and clear the counter and shadow registers.
REQ-029 On reset, the block SHALL drive o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_err=0, o_err_code=00 and o_busy=0.
REQ-030 A reset mid-frame SHALL discard the partial frame with no error strobe.
REQ-031 The block SHALL ignore i_valid in any cycle where i_reset=1.

Structure
REQ-032 Shared package fse_cfg_pkg SHALL hold the state encoding, the error code constants and the default SYNC value.
REQ-033 The timeout counter SHALL be a sub-module byte_timeout, with ports clear, enable and expired, and parameter TIMEOUT.
REQ-034 All outputs SHALL be registered, with no combinational path from i_valid or i_data to any output.

Verification
REQ-035 The bench SHALL cover a valid frame: A5,10,12,34,36 -> one o_wr_en pulse 1 cycle after the last strobe, with o_wr_addr=10 and o_wr_data=1234.
REQ-036 The bench SHALL cover a bad checksum: A5,10,12,34,00 -> o_err=1 with code 01, no o_wr_en, and addr/data unchanged.
REQ-037 The bench SHALL cover garbage before sync: 00,FF,A5,01,00,02,03 -> exactly one write, addr=01, data=0002, and no o_err.
REQ-038 The bench SHALL cover a timeout: A5,10 followed by 1024 idle cycles -> o_err with code 10, o_busy=0, and a subsequent valid frame accepted.
REQ-039 The bench SHALL cover a boundary race: a byte strobe in the exact expiry cycle -> no timeout error and the frame completes.
REQ-040 The bench SHALL cover reset mid-frame: A5,10,12, then i_reset for 1 cycle, then 34,26 -> no write, no error, o_busy=0.
